// File: rtl/ws2812b_strip_ctrl.sv
// Frame sequencer for a WS2812B chain: fetches pixels from RAM, applies global brightness,
// hands each pixel to the single-pixel encoder, then holds the latch gap and pulses done.
module ws2812b_strip_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int LATCH_CNT = 8100
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_repeat_en,
  input  logic [ADDR_W:0]   i_num_leds,
  input  logic [7:0]        i_bright,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_rd,
  input  logic [23:0]       i_ram_data,
  output logic              o_px_en,
  output logic [7:0]        o_px_red,
  output logic [7:0]        o_px_green,
  output logic [7:0]        o_px_blue,
  input  logic              i_px_busy,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = (LATCH_CNT > 2) ? $clog2(LATCH_CNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_LATCH, S_DONE
  } state_t;

  state_t            r_state, w_state;
  logic [ADDR_W:0]   r_n, w_n;
  logic [7:0]        r_br, w_br;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic              r_ram_rd, w_ram_rd;
  logic              r_px_en, w_px_en;
  logic [7:0]        r_red, w_red;
  logic [7:0]        r_green, w_green;
  logic [7:0]        r_blue, w_blue;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              w_begin;
  logic              w_last;

  // c' = (c * (br + 1)) >> 8, so br=255 is a pass-through and br=0 blanks the channel
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] p;
    p = 16'(c) * (16'(br) + 16'd1);
    return 8'(p >> 8);
  endfunction

  assign w_last = ({1'b0, r_idx} == (r_n - {{ADDR_W{1'b0}}, 1'b1}));

  always_comb begin
    w_state    = r_state;
    w_n        = r_n;
    w_br       = r_br;
    w_idx      = r_idx;
    w_cnt      = r_cnt;
    w_ram_addr = r_ram_addr;
    w_ram_rd   = 1'b0;
    w_px_en    = 1'b0;
    w_red      = r_red;
    w_green    = r_green;
    w_blue     = r_blue;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_begin    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_begin = 1'b1;
      end
      S_FETCH: w_state = S_LOAD;
      S_LOAD: begin
        w_green = scale(i_ram_data[23:16], r_br);
        w_red   = scale(i_ram_data[15:8],  r_br);
        w_blue  = scale(i_ram_data[7:0],   r_br);
        w_state = S_SEND;
      end
      S_SEND: begin
        if (!i_px_busy) begin
          w_px_en = 1'b1;
          w_state = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (i_px_busy) w_state = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!i_px_busy) begin
          if (w_last) begin
            w_cnt   = '0;
            w_state = S_LATCH;
          end else begin
            w_idx      = r_idx + 1'b1;
            w_ram_addr = r_idx + 1'b1;
            w_ram_rd   = 1'b1;
            w_state    = S_FETCH;
          end
        end
      end
      S_LATCH: begin
        if (r_cnt == CNT_W'(LATCH_CNT - 1)) begin
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (i_repeat_en) begin
          w_begin = 1'b1;
        end else begin
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_busy  = 1'b0;
        w_state = S_IDLE;
      end
    endcase

    // Shared frame entry for a fresh start and for an auto-repeat
    if (w_begin) begin
      w_n    = i_num_leds;
      w_br   = i_bright;
      w_idx  = '0;
      w_cnt  = '0;
      w_busy = 1'b1;
      if (i_num_leds != '0) begin
        w_ram_addr = '0;
        w_ram_rd   = 1'b1;
        w_state    = S_FETCH;
      end else begin
        w_state = S_LATCH;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_br       <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_ram_addr <= '0;
      r_ram_rd   <= 1'b0;
      r_px_en    <= 1'b0;
      r_red      <= '0;
      r_green    <= '0;
      r_blue     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_n        <= w_n;
      r_br       <= w_br;
      r_idx      <= w_idx;
      r_cnt      <= w_cnt;
      r_ram_addr <= w_ram_addr;
      r_ram_rd   <= w_ram_rd;
      r_px_en    <= w_px_en;
      r_red      <= w_red;
      r_green    <= w_green;
      r_blue     <= w_blue;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign o_ram_addr = r_ram_addr;
  assign o_ram_rd   = r_ram_rd;
  assign o_px_en    = r_px_en;
  assign o_px_red   = r_red;
  assign o_px_green = r_green;
  assign o_px_blue  = r_blue;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_ws2812b_strip_ctrl.sv
// Randomized bench for ws2812b_strip_ctrl: a RAM model, a behavioural encoder model and a
// pixel-list reference model built from the brightness formula.
module tb_ws2812b_strip_ctrl;

  localparam int AW   = 4;
  localparam int LC   = 40;
  localparam int MAXN = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic          repeatEn;
  logic [AW:0]   numLeds;
  logic [7:0]    bright;
  logic [AW-1:0] ramAddr;
  logic          ramRd;
  logic [23:0]   ramData;
  logic          pxEn;
  logic [7:0]    pxR, pxG, pxB;
  logic          pxBusy;
  logic          busy;
  logic          done;

  logic [23:0] mem [0:MAXN-1];
  int          checkCnt = 0;
  int          passCnt  = 0;
  int          encCycles = 8;
  int          encCnt;
  int          doneCnt;
  int          busyCyc;
  int          busyLowCnt;
  bit          trackLow = 1'b0;
  logic        prevPxBusy = 1'b0;
  logic [23:0] lastEnPix = '0;
  int          addrQ[$];
  logic [23:0] pixQ[$];

  ws2812b_strip_ctrl #(.ADDR_W(AW), .LATCH_CNT(LC)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_repeat_en(repeatEn),
    .i_num_leds(numLeds), .i_bright(bright), .o_ram_addr(ramAddr), .o_ram_rd(ramRd),
    .i_ram_data(ramData), .o_px_en(pxEn), .o_px_red(pxR), .o_px_green(pxG),
    .o_px_blue(pxB), .i_px_busy(pxBusy), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // Pixel RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ramRd) ramData <= mem[ramAddr];
  end

  // Encoder: busy for encCycles cycles after an accepted en, reset together with the DUT
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pxBusy <= 1'b0;
      encCnt <= 0;
    end else if (pxBusy) begin
      if (encCnt <= 1) pxBusy <= 1'b0;
      else encCnt <= encCnt - 1;
    end else if (pxEn) begin
      pxBusy <= 1'b1;
      encCnt <= encCycles;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor samples on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (ramRd) addrQ.push_back(int'(ramAddr));
    if (pxEn) begin
      pixQ.push_back({pxG, pxR, pxB});
      lastEnPix = {pxG, pxR, pxB};
    end
    if (done) doneCnt++;
    if (busy) busyCyc++;
    if (trackLow && !busy) busyLowCnt++;
    if (prevPxBusy && !pxBusy && rstN)
      checkOutput("pxHold", {8'h0, pxG, pxR, pxB}, {8'h0, lastEnPix});
    prevPxBusy = pxBusy;
  end

  function automatic logic [23:0] refPixel(input logic [23:0] w, input int br);
    int g, r, b;
    g = int'(w[23:16]) * (br + 1) / 256;
    r = int'(w[15:8])  * (br + 1) / 256;
    b = int'(w[7:0])   * (br + 1) / 256;
    return {g[7:0], r[7:0], b[7:0]};
  endfunction

  task automatic waitDone(input int target, input int budget);
    int k = 0;
    while (doneCnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (doneCnt < target) checkOutput("doneTimeout", doneCnt, target);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < MAXN; i++) mem[i] = 24'($urandom);
  endtask

  // Runs one frame and compares the fetched addresses and delivered pixels against the model
  task automatic applyStimulus(input int n, input int br, input bit disturb);
    int k;
    doneCnt = 0;
    busyCyc = 0;
    addrQ.delete();
    pixQ.delete();
    @(negedge clk);
    numLeds = (AW+1)'(n);
    bright  = 8'(br);
    pulseStart();
    if (disturb) begin
      k = 0;
      while (pixQ.size() < 1 && k < 500) begin
        @(negedge clk); #1;
        k++;
      end
      numLeds = (AW+1)'(2);
      bright  = ~8'(br);
      pulseStart();
    end
    waitDone(1, n * (encCycles + 12) + LC + 100);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("doneCnt", doneCnt, 1);
    checkOutput("pxCount", pixQ.size(), n);
    checkOutput("rdCount", addrQ.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < addrQ.size()) checkOutput("ramAddr", addrQ[i], i);
      if (i < pixQ.size())  checkOutput("pixel", {8'h0, pixQ[i]}, {8'h0, refPixel(mem[i], br)});
    end
    checkOutput("busyIdle", busy, 0);
  endtask

  initial begin
    int k;
    rstN = 1'b0; start = 1'b0; repeatEn = 1'b0; numLeds = '0; bright = '0;
    ramData = '0;
    doneCnt = 0; busyCyc = 0; busyLowCnt = 0;
    fillRandom();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstPxEn", pxEn, 0);
    checkOutput("rstRamRd", ramRd, 0);
    checkOutput("rstAddr", ramAddr, 0);
    checkOutput("rstPx", {pxG, pxR, pxB}, 0);
    rstN = 1'b1;

    // Basic three-pixel frame at full brightness with a slow encoder
    encCycles = 50;
    mem[0] = 24'h112233; mem[1] = 24'h445566; mem[2] = 24'h778899;
    applyStimulus(3, 255, 1'b0);

    // Brightness scaling corner values
    encCycles = 6;
    mem[0] = 24'hFF8001;
    applyStimulus(1, 127, 1'b0);
    checkOutput("br127", {8'h0, pxG, pxR, pxB}, 32'h007F4000);
    applyStimulus(1, 0, 1'b0);
    checkOutput("br0", {8'h0, pxG, pxR, pxB}, 0);

    // Empty frame goes straight to the latch gap
    applyStimulus(0, 200, 1'b0);
    checkOutput("latchLen", (busyCyc >= LC && busyCyc <= LC + 3), 1);

    // Mid-frame start and num_leds/bright changes must not alter the frame
    fillRandom();
    encCycles = 10;
    applyStimulus(5, 90, 1'b1);

    // Full-length chain and randomized frames
    fillRandom();
    encCycles = 3;
    applyStimulus(MAXN, int'($urandom_range(0, 255)), 1'b0);
    for (int t = 0; t < 6; t++) begin
      fillRandom();
      encCycles = int'($urandom_range(1, 20));
      applyStimulus(int'($urandom_range(1, MAXN)), int'($urandom_range(0, 255)), 1'b0);
    end

    // Auto-repeat: busy stays high across frames, then stops after repeat_en clears
    fillRandom();
    encCycles = 5;
    doneCnt = 0; busyLowCnt = 0;
    addrQ.delete(); pixQ.delete();
    repeatEn = 1'b1;
    numLeds = (AW+1)'(2);
    bright = 8'd200;
    pulseStart();
    trackLow = 1'b1;
    waitDone(3, 3 * (2 * 30 + LC + 50));
    @(posedge clk); #1;
    repeatEn = 1'b0;
    waitDone(4, 2 * 30 + LC + 50);
    trackLow = 1'b0;
    repeat (LC + 20) @(negedge clk);
    #1;
    checkOutput("repDone", doneCnt, 4);
    checkOutput("repBusyLow", busyLowCnt, 0);
    checkOutput("repPxCount", pixQ.size(), 8);
    checkOutput("repBusyEnd", busy, 0);
    for (int i = 0; i < 8 && i < pixQ.size(); i++)
      checkOutput("repPixel", {8'h0, pixQ[i]}, {8'h0, refPixel(mem[i % 2], 200)});

    // Asynchronous reset while waiting on the second pixel's encoder
    encCycles = 12;
    doneCnt = 0;
    pixQ.delete();
    numLeds = (AW+1)'(3);
    bright = 8'd255;
    pulseStart();
    k = 0;
    while (pixQ.size() < 2 && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    checkOutput("rstReach", (pixQ.size() >= 2), 1);
    repeat (4) @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstPxEn", pxEn, 0);
    checkOutput("midRstRamRd", ramRd, 0);
    checkOutput("midRstAddr", ramAddr, 0);
    checkOutput("midRstPx", {pxG, pxR, pxB}, 0);
    repeat (LC + 10) @(negedge clk);
    checkOutput("midRstNoDone", doneCnt, 0);
    rstN = 1'b1;
    fillRandom();
    encCycles = 4;
    applyStimulus(2, 255, 1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
